wshb_arbiter: RTL and testbench
===============================

// Module: wshb_arbiter
// PURPOSE
// - Shares one Wishbone slave port (SDRAM controller) between two Wishbone masters:
//   M0 = video frame reader (display refill), M1 = framebuffer writer (test-pattern generator).
// - Grants one whole cycle (cyc high span) at a time; muxes the winner's request onto the slave
//   and routes ack/data back to the winner only. Sits between the masters and the SDRAM bridge.
// PARAMETERS
// - AW        32  address width (byte address)
// - DW        32  data width; SW = DW/8 byte selects
// - FIXED_PRIO 0  0 = round-robin between M0/M1; 1 = M0 always wins simultaneous requests
// PORTS
// - clk          in   1   system clock
// - rst_n        in   1   asynchronous reset, active low
// - m0_cyc,m0_stb,m0_we   in 1 each   M0 request (same for m1_*)
// - m0_adr       in   AW  M0 address;  m0_dat_ms in DW; m0_sel in SW; m0_cti in 3; m0_bte in 2
// - m0_ack       out  1   ack to M0;   m0_dat_sm out DW read data to M0 (same for m1_*)
// - s_cyc,s_stb,s_we      out 1 each  muxed request to slave
// - s_adr out AW; s_dat_ms out DW; s_sel out SW; s_cti out 3; s_bte out 2
// - s_ack        in   1   slave ack;   s_dat_sm in DW slave read data
// - gnt          out  2   one-hot current grant {M1,M0}; 2'b00 when idle
// BEHAVIOUR
// - FSM states IDLE, GNT0, GNT1; registered state; async reset -> IDLE, last_gnt <= 1 (M0 first).
// - Reset values: gnt=0; all s_* outputs 0; m*_ack=0; m*_dat_sm=0 (outputs decode from state,
//   so they drop to 0 immediately on rst_n assertion, also mid-cycle).
// - IDLE: only m0_cyc -> GNT0; only m1_cyc -> GNT1; both -> FIXED_PRIO ? GNT0 : the master
//   not in last_gnt. Grant latency: request seen cycle N, slave sees it cycle N+1.
// - GNTx: held while mx_cyc=1, regardless of stb/ack (no preemption, no timeout).
//   mx_cyc=0 -> if other master's cyc=1 go directly to its grant (no idle bubble), else IDLE.
//   last_gnt <= x on leaving GNTx.
// - Request mux (combinational from state): in GNTx, s_* = mx_*, but s_cyc = mx_cyc and
//   s_stb = mx_cyc & mx_stb; in IDLE all s_* = 0.
// - Response routing: mx_ack = s_ack & (state==GNTx) & mx_cyc; mx_dat_sm = s_dat_sm when
//   GNTx else 0. Non-granted master never sees ack; its request is held pending (it keeps stb).
// - Slave ack arriving in the cycle the granted master drops cyc: discarded, not forwarded.
// - Simultaneous release by M0 and new request by M1 in same cycle: GNT1 next cycle.
// - Round-robin guarantee: with both masters continuously requesting, grants alternate
//   M0,M1,M0,... per cycle-span. FIXED_PRIO=1 may starve M1 (documented, display has priority).
// - No combinational path from s_ack to s_cyc/s_stb; one registered level (state) only.
// STRUCTURE
// - Package wshb_arb_pkg: typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t; localparams
//   CTI_CLASSIC=3'b000, BTE_LINEAR=2'b00.
// - Single module; no sub-module. Top level wraps it to wshb_if.slave x2 / wshb_if.master x1.
// TESTING
// - Reset: hold rst_n=0 with both cyc=1 -> gnt=00, s_cyc=0, m0_ack=m1_ack=0; release -> GNT0 next clk.
// - M1 alone: m1 writes 4 words adr 0x0,0x4,0x8,0xC, slave acks 1 clk later each -> s_adr matches,
//   m1_ack x4, m0_ack stays 0, gnt=10.
// - Contention RR: both cyc=1 from reset, each drops cyc after 8 acks -> grants M0,M1,M0,M1,
//   handover with 0 idle cycles, gnt never 11.
// - FIXED_PRIO=1 contention -> M0 wins every arbitration; M1 granted only while m0_cyc=0.
// - Read routing: M0 read, slave returns s_dat_sm=0xDEADBEEF with ack -> m0_dat_sm=0xDEADBEEF,
//   m1_dat_sm=0.
// - Async reset mid-burst (GNT1, after 3 acks) -> s_cyc=0 same cycle; after release M0 granted first.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: grants one whole Wishbone cycle at a time to M0 (video reader) or M1
// (framebuffer writer) and routes the shared slave's ack/data back to the winner only.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter  int AW         = 32,
    parameter  int DW         = 32,
    parameter  int FIXED_PRIO = 0,
    localparam int SW         = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_ms_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_dat_sm_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_ms_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_dat_sm_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_ms_o,
    output logic [SW-1:0] s_sel_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_dat_sm_i,
    output logic [1:0]    gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       g0, g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // last_q is the master granted most recently; the other one wins the next tie.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: state_d = (m0_cyc_i && (!m1_cyc_i || FIXED_PRIO != 0 || last_q)) ? GNT0 :
                            m1_cyc_i ? GNT1 : IDLE;
            GNT0: if (!m0_cyc_i) begin
                state_d = m1_cyc_i ? GNT1 : IDLE;
                last_d  = 1'b0;
            end
            GNT1: if (!m1_cyc_i) begin
                state_d = m0_cyc_i ? GNT0 : IDLE;
                last_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign g0    = state_q == GNT0;
    assign g1    = state_q == GNT1;
    assign gnt_o = {g1, g0};

    // Gating with the granted master's cyc keeps a late slave ack from leaking past release.
    assign s_cyc_o    = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign s_stb_o    = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);
    assign s_we_o     = (g0 & m0_we_i) | (g1 & m1_we_i);
    assign s_adr_o    = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    assign s_dat_ms_o = g0 ? m0_dat_ms_i : g1 ? m1_dat_ms_i : '0;
    assign s_sel_o    = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
    assign s_cti_o    = g0 ? m0_cti_i : g1 ? m1_cti_i : CTI_CLASSIC;
    assign s_bte_o    = g0 ? m0_bte_i : g1 ? m1_bte_i : BTE_LINEAR;

    assign m0_ack_o    = s_ack_i & g0 & m0_cyc_i;
    assign m1_ack_o    = s_ack_i & g1 & m1_cyc_i;
    assign m0_dat_sm_o = g0 ? s_dat_sm_i : '0;
    assign m1_dat_sm_o = g1 ? s_dat_sm_i : '0;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: cycle vector table for both priority modes, plus scoreboarded bursts,
// round-robin contention and an asynchronous reset in the middle of a burst.
module tb_wshb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_ms_i, m1_adr_i, m1_dat_ms_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [2:0]  m0_cti_i, m1_cti_i;
    logic [1:0]  m0_bte_i, m1_bte_i;
    logic        s_ack_i;
    logic [31:0] s_dat_sm_i;
    logic        m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] m0_dat_sm_o, m1_dat_sm_o, s_adr_o, s_dat_ms_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o, gnt_o;
    logic        fp_m0_ack, fp_m1_ack, fp_s_cyc, fp_s_stb, fp_s_we;
    logic [31:0] fp_m0_dat, fp_m1_dat, fp_s_adr, fp_s_dat;
    logic [3:0]  fp_s_sel;
    logic [2:0]  fp_s_cti;
    logic [1:0]  fp_s_bte, fp_gnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wshb_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_ms_i(m0_dat_ms_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_ack_o(m0_ack_o), .m0_dat_sm_o(m0_dat_sm_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_ms_i(m1_dat_ms_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_ack_o(m1_ack_o), .m1_dat_sm_o(m1_dat_sm_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_ms_o(s_dat_ms_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_ack_i(s_ack_i), .s_dat_sm_i(s_dat_sm_i), .gnt_o(gnt_o)
    );

    wshb_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_dat_ms_i(m0_dat_ms_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_ack_o(fp_m0_ack), .m0_dat_sm_o(fp_m0_dat),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_ms_i(m1_dat_ms_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_ack_o(fp_m1_ack), .m1_dat_sm_o(fp_m1_dat),
        .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we), .s_adr_o(fp_s_adr),
        .s_dat_ms_o(fp_s_dat), .s_sel_o(fp_s_sel), .s_cti_o(fp_s_cti), .s_bte_o(fp_s_bte),
        .s_ack_i(s_ack_i), .s_dat_sm_i(s_dat_sm_i), .gnt_o(fp_gnt)
    );

    typedef struct packed {
        logic       rst_n, m0c, m0s, m1c, m1s, ack;
        logic [1:0] gnt, gnt_fp;
        logic       scyc, sstb, a0, a1;
    } vec_t;

    typedef struct {
        logic [31:0] adr, wdat, rdat;
    } exp_t;

    vec_t        tbl [11];
    exp_t        q [$];
    logic [1:0]  gq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drv(input bit m, input logic c, input logic [31:0] a, input logic [31:0] d,
                       input logic w);
        if (m) begin
            m1_cyc_i = c; m1_stb_i = c; m1_adr_i = a; m1_dat_ms_i = d; m1_we_i = w; m1_sel_i = 4'hC;
        end else begin
            m0_cyc_i = c; m0_stb_i = c; m0_adr_i = a; m0_dat_ms_i = d; m0_we_i = w; m0_sel_i = 4'h3;
        end
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        s_ack_i = 0; s_dat_sm_i = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Single master burst; slave acks one clock after seeing stb, read data = DEADBEEF + word index.
    task automatic burst(input bit m, input int n, input logic we);
        int          k = 0;
        int          cnt = 0;
        exp_t        e;
        logic        nack, adv;
        logic [31:0] nadr;
        q.push_back('{32'(0), 32'hA5A50000, 32'hDEADBEEF});
        drv(m, 1, 0, 32'hA5A50000, we);
        s_ack_i = 0;
        while (k < n && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (s_ack_i) begin
                e = q.pop_front();
                chk($sformatf("m%0d beat%0d adr", m, k), s_adr_o, e.adr);
                chk($sformatf("m%0d beat%0d sel", m, k), s_sel_o, m ? 4'hC : 4'h3);
                chk($sformatf("m%0d beat%0d own ack", m, k), m ? m1_ack_o : m0_ack_o, 1);
                chk($sformatf("m%0d beat%0d other ack", m, k), m ? m0_ack_o : m1_ack_o, 0);
                chk($sformatf("m%0d beat%0d gnt", m, k), gnt_o, m ? 2'b10 : 2'b01);
                if (we)
                    chk($sformatf("m%0d beat%0d wdat", m, k), s_dat_ms_o, e.wdat);
                else begin
                    chk($sformatf("m%0d beat%0d rdat", m, k), m ? m1_dat_sm_o : m0_dat_sm_o, e.rdat);
                    chk($sformatf("m%0d beat%0d other rdat", m, k), m ? m0_dat_sm_o : m1_dat_sm_o, 0);
                end
            end
            adv  = m ? m1_ack_o : m0_ack_o;
            nack = s_cyc_o & s_stb_o & !s_ack_i;
            nadr = s_adr_o;
            @(posedge clk);
            #1;
            s_ack_i    = nack;
            s_dat_sm_i = nack ? 32'hDEADBEEF + (nadr >> 2) : '0;
            if (adv) begin
                k++;
                if (k < n) begin
                    q.push_back('{32'(4 * k), 32'hA5A50000 + 32'(k), 32'hDEADBEEF + 32'(k)});
                    drv(m, 1, 32'(4 * k), 32'hA5A50000 + 32'(k), we);
                end else
                    drv(m, 0, 0, 0, 0);
            end
        end
        chk($sformatf("m%0d burst beats before timeout", m), k, n);
        q.delete();
        drv(m, 0, 0, 0, 0);
        s_ack_i = 0;
    endtask

    // Both masters run two 8-beat bursts each, dropping cyc for one cycle in between.
    task automatic contention();
        int         c0 = 0, c1 = 0, b0 = 0, b1 = 0, cnt = 0, idle = 0;
        logic       a0, a1, nack, started = 0;
        logic [1:0] g, prev = 2'b00;
        gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
        drv(0, 1, 0, 0, 1);
        drv(1, 1, 0, 0, 1);
        while ((b0 < 2 || b1 < 2) && cnt < 400) begin
            @(negedge clk);
            cnt++;
            g = gnt_o;
            if (g == 2'b11) chk("rr gnt not both", g, 2'b00);
            if (g != 2'b00 && g != prev) begin
                if (gq.size() == 0) chk("rr extra grant", g, 2'b00);
                else chk("rr grant order", g, gq.pop_front());
                prev = g;
            end
            if (g != 2'b00) started = 1;
            if (started && g == 2'b00 && (m0_cyc_i || m1_cyc_i)) idle++;
            a0   = m0_ack_o;
            a1   = m1_ack_o;
            nack = s_cyc_o & s_stb_o & !s_ack_i;
            @(posedge clk);
            #1;
            s_ack_i = nack;
            if (!m0_cyc_i) begin
                if (b0 < 2) drv(0, 1, 0, 0, 1);
            end else if (a0) begin
                c0++;
                if (c0 == 8) begin c0 = 0; b0++; drv(0, 0, 0, 0, 0); end
                else drv(0, 1, 32'(4 * c0), 0, 1);
            end
            if (!m1_cyc_i) begin
                if (b1 < 2) drv(1, 1, 0, 0, 1);
            end else if (a1) begin
                c1++;
                if (c1 == 8) begin c1 = 0; b1++; drv(1, 0, 0, 0, 0); end
                else drv(1, 1, 32'(4 * c1), 0, 1);
            end
        end
        chk("rr bursts finished", b0 + b1, 4);
        chk("rr grants left", gq.size(), 0);
        chk("rr idle bubbles", idle, 0);
        gq.delete();
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        s_ack_i = 0;
    endtask

    initial begin
        m0_cti_i = 3'b000; m1_cti_i = 3'b000; m0_bte_i = 2'b00; m1_bte_i = 2'b00;
        do_reset();

        //           rst m0c m0s m1c m1s ack  gnt    gnt_fp scyc sstb a0 a1
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst_n = tbl[i].rst_n;
            m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s;
            m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1s;
            s_ack_i = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d gnt", i), gnt_o, tbl[i].gnt);
            chk($sformatf("vec%0d gnt_fp", i), fp_gnt, tbl[i].gnt_fp);
            chk($sformatf("vec%0d s_cyc", i), s_cyc_o, tbl[i].scyc);
            chk($sformatf("vec%0d s_stb", i), s_stb_o, tbl[i].sstb);
            chk($sformatf("vec%0d m0_ack", i), m0_ack_o, tbl[i].a0);
            chk($sformatf("vec%0d m1_ack", i), m1_ack_o, tbl[i].a1);
            @(posedge clk);
            #1;
        end

        do_reset();
        burst(1, 4, 1);
        burst(0, 2, 0);

        do_reset();
        contention();

        // Reset asserted mid-cycle while M1 owns the slave.
        do_reset();
        begin
            int acks = 0, cnt = 0;
            logic nack;
            drv(1, 1, 0, 0, 1);
            while (acks < 3 && cnt < 100) begin
                @(negedge clk);
                cnt++;
                if (m1_ack_o) acks++;
                nack = s_cyc_o & s_stb_o & !s_ack_i;
                @(posedge clk);
                #1;
                s_ack_i = nack;
            end
            chk("mid reset acks before timeout", acks, 3);
            drv(0, 1, 0, 0, 0);
            s_ack_i = 0;
            #2;
            chk("mid reset pre gnt", gnt_o, 2'b10);
            rst_n = 0;
            #1;
            chk("mid reset s_cyc", s_cyc_o, 0);
            chk("mid reset s_stb", s_stb_o, 0);
            chk("mid reset gnt", gnt_o, 2'b00);
            chk("mid reset m1_ack", m1_ack_o, 0);
            @(posedge clk);
            #1 rst_n = 1;
            @(negedge clk);
            chk("post reset gnt idle", gnt_o, 2'b00);
            @(negedge clk);
            chk("post reset M0 first", gnt_o, 2'b01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
